mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 32-bit MIPS pipeline. It sits directly downstream of the EX/MEM register and consumes its control bits, ALU result (address), RT store data and destination register number. It performs the data-memory word access and registers the write-back bundle. It drives the register file write port and the MEM/WB forwarding path back to the EX stage.

## Interface
Parameters:
- n, 32, datapath width
- DEPTH, 256, data memory size in 32-bit words (power of two)
- AW, 8, word-index width, log2(DEPTH)

Ports:
- clk  in  1  rising-edge clock
- reset_in  in  1  asynchronous, active-high reset
- stall_in  in  1  hold MEM/WB register; suppress memory write
- flush_in  in  1  bubble current instruction (highest priority after reset)
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control from EX/MEM
- ALU_Result_in  in  n  byte address / ALU result
- RT_data_in  in  n  store data
- Write_Reg_in  in  5  destination register
- RegWrite_out, MemtoReg_out  out  1 each  registered control
- Read_Data_out  out  n  registered memory read data
- ALU_Result_out  out  n  registered ALU result
- Write_Reg_out  out  5  registered destination
- WB_Data_out  out  n  combinational: MemtoReg_out ? Read_Data_out : ALU_Result_out
- Mem_Fault_out  out  1  registered one-cycle fault flag
- Fault_Count_out  out  8  saturating fault counter

## Operation
- Word index = ALU_Result_in[AW+1:2]. An access is one with MemRead_in or MemWrite_in set.
- Fault: the access has ALU_Result_in[1:0] != 0, or ALU_Result_in[n-1:AW+2] != 0.
- Store: the array word is written at the rising edge when MemWrite_in=1, no fault, stall_in=0, flush_in=0, reset_in=0.
- Load: the array is read combinationally at the word index. The result is captured into Read_Data_out at the edge. A faulting read captures 0.
- MemRead_in and MemWrite_in both high: treat as a store. Read_Data_out captures the old word.
- Register update at the edge, in priority order:
  - reset_in: all outputs cleared.
  - flush_in=1: RegWrite_out=0, MemtoReg_out=0, Write_Reg_out=0, Mem_Fault_out=0. Data registers captured normally (don't-care).
  - stall_in=1: all registers hold. Mem_Fault_out is cleared to 0 so a fault is not re-reported while stalled.
  - Otherwise, capture all fields. On a fault, RegWrite_out is forced 0, Mem_Fault_out=1 and Fault_Count_out increments, saturating at 8'hFF.
- Write_Reg_in=0 with RegWrite_in=1 passes through unchanged. The register file ignores writes to $0.
- Array contents are not affected by reset. Reads of never-written words are undefined (X permitted).

## Timing
- Reset values: every output 0 (WB_Data_out=0 follows).
- Latency: inputs present before edge N appear on the outputs after edge N (1 cycle).
- Store at edge N, load of the same word at edge N+1: the load returns the new data, with no bypass needed.
- Mem_Fault_out is high for exactly one cycle per faulting, non-stalled, non-flushed instruction.
- Asserting reset_in mid-stream clears outputs immediately, without waiting for a clock edge. A store presented in the reset cycle is not written.
- Simultaneous stall_in and flush_in: flush wins.
- Forwarding path = {RegWrite_out, Write_Reg_out, WB_Data_out}, valid throughout the cycle after the edge.

## Test plan
- Reset: drive reset_in high mid-cycle -> all outputs 0 immediately; Fault_Count_out=0.
- Store then load: store 32'hDEADBEEF at address 32'h10, then load address 32'h10 with MemtoReg=1, RegWrite=1, Write_Reg=5'd8 -> next cycle Read_Data_out=WB_Data_out=32'hDEADBEEF, Write_Reg_out=8.
- ALU passthrough: RegWrite=1, MemtoReg=0, ALU_Result_in=32'h9, Write_Reg=3 -> WB_Data_out=32'h9, no memory access, no fault.
- Faults:
  - Load address 32'h2 -> RegWrite_out=0, Read_Data_out=0, Mem_Fault_out pulses 1 cycle, Fault_Count_out=1.
  - Store address 32'h400 (DEPTH=256) -> fault, memory unchanged; verify by reloading word 0.
- Stall and flush:
  - Store with stall_in=1 -> array unchanged and outputs hold their prior values.
  - Same store with flush_in=1 -> not written and RegWrite_out=0.
  - Stall and flush both high -> flush behaviour.
- Saturation: 260 consecutive faulting loads -> Fault_Count_out stops at 8'hFF, Mem_Fault_out pulses each cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Data memory access plus MEM/WB register.
// Drives the register file write port and MEM/WB forwarding path.
module mem_wb_stage #(
  parameter int n     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         stall_in,
  input  logic         flush_in,
  input  logic         RegWrite_in,
  input  logic         MemtoReg_in,
  input  logic         MemRead_in,
  input  logic         MemWrite_in,
  input  logic [n-1:0] ALU_Result_in,
  input  logic [n-1:0] RT_data_in,
  input  logic [4:0]   Write_Reg_in,
  output logic         RegWrite_out,
  output logic         MemtoReg_out,
  output logic [n-1:0] Read_Data_out,
  output logic [n-1:0] ALU_Result_out,
  output logic [4:0]   Write_Reg_out,
  output logic [n-1:0] WB_Data_out,
  output logic         Mem_Fault_out,
  output logic [7:0]   Fault_Count_out
);

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] widx;
  logic          access;
  logic          misalign;
  logic          oob;
  logic          fault;
  logic          mem_we;
  logic [n-1:0]  rd_data;

  assign widx     = ALU_Result_in[AW+1:2];
  assign access   = MemRead_in | MemWrite_in;
  assign misalign = |ALU_Result_in[1:0];
  assign oob      = |ALU_Result_in[n-1:AW+2];
  assign fault    = access & (misalign | oob);

  // A store commits only for a clean, live instruction.
  assign mem_we = MemWrite_in & ~fault & ~stall_in
                & ~flush_in & ~reset_in;

  // Read-before-write: a combined read/write returns the old word.
  assign rd_data = fault ? '0 : mem[widx];

  // Word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[widx] <= RT_data_in;
  end

  // MEM/WB register: reset, then flush, then stall, then capture.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      RegWrite_out    <= 1'b0;
      MemtoReg_out    <= 1'b0;
      Read_Data_out   <= '0;
      ALU_Result_out  <= '0;
      Write_Reg_out   <= '0;
      Mem_Fault_out   <= 1'b0;
      Fault_Count_out <= '0;
    end else if (flush_in) begin
      RegWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      Write_Reg_out  <= '0;
      Mem_Fault_out  <= 1'b0;
      Read_Data_out  <= rd_data;
      ALU_Result_out <= ALU_Result_in;
    end else if (stall_in) begin
      Mem_Fault_out <= 1'b0;
    end else begin
      RegWrite_out   <= RegWrite_in & ~fault;
      MemtoReg_out   <= MemtoReg_in;
      Write_Reg_out  <= Write_Reg_in;
      Read_Data_out  <= rd_data;
      ALU_Result_out <= ALU_Result_in;
      Mem_Fault_out  <= fault;
      if (fault && Fault_Count_out != 8'hFF)
        Fault_Count_out <= Fault_Count_out + 8'd1;
    end
  end

  // Write-back select, also the forwarding data.
  assign WB_Data_out = MemtoReg_out ? Read_Data_out
                                    : ALU_Result_out;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Table vectors plus reset and saturation sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        stall_in, flush_in;
  logic        RegWrite_in, MemtoReg_in;
  logic        MemRead_in, MemWrite_in;
  logic [31:0] ALU_Result_in, RT_data_in;
  logic [4:0]  Write_Reg_in;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] Read_Data_out, ALU_Result_out;
  logic [4:0]  Write_Reg_out;
  logic [31:0] WB_Data_out;
  logic        Mem_Fault_out;
  logic [7:0]  Fault_Count_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.n(32), .DEPTH(256), .AW(8)) dut (
    .clk             (clk),
    .reset_in        (reset_in),
    .stall_in        (stall_in),
    .flush_in        (flush_in),
    .RegWrite_in     (RegWrite_in),
    .MemtoReg_in     (MemtoReg_in),
    .MemRead_in      (MemRead_in),
    .MemWrite_in     (MemWrite_in),
    .ALU_Result_in   (ALU_Result_in),
    .RT_data_in      (RT_data_in),
    .Write_Reg_in    (Write_Reg_in),
    .RegWrite_out    (RegWrite_out),
    .MemtoReg_out    (MemtoReg_out),
    .Read_Data_out   (Read_Data_out),
    .ALU_Result_out  (ALU_Result_out),
    .Write_Reg_out   (Write_Reg_out),
    .WB_Data_out     (WB_Data_out),
    .Mem_Fault_out   (Mem_Fault_out),
    .Fault_Count_out (Fault_Count_out)
  );

  typedef struct {
    logic        st, fl, rw, m2r, mr, mw;
    logic [31:0] alu, rt;
    logic [4:0]  wr;
    logic        e_rw, e_m2r;
    logic [4:0]  e_wr;
    logic [31:0] e_alu, e_wb;
    logic        e_flt;
    logic [7:0]  e_cnt;
    logic        ck_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_rd(input string nm,
                        input logic [31:0] exp);
    n_cmp++;
    if (Read_Data_out !== exp) begin
      n_bad++;
      $display("FAIL %s rd: got %h want %h",
               nm, Read_Data_out, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return {RegWrite_out, MemtoReg_out, Write_Reg_out,
            ALU_Result_out, WB_Data_out,
            Mem_Fault_out, Fault_Count_out};
  endfunction

  task automatic drive(input vec_t v);
    stall_in      = v.st;
    flush_in      = v.fl;
    RegWrite_in   = v.rw;
    MemtoReg_in   = v.m2r;
    MemRead_in    = v.mr;
    MemWrite_in   = v.mw;
    ALU_Result_in = v.alu;
    RT_data_in    = v.rt;
    Write_Reg_in  = v.wr;
  endtask

  task automatic apply(input vec_t v, input string nm);
    drive(v);
    @(posedge clk);
    #1;
    chk(nm, outs(),
        {v.e_rw, v.e_m2r, v.e_wr, v.e_alu,
         v.e_wb, v.e_flt, v.e_cnt});
    if (v.ck_rd)
      chk_rd(nm, v.e_rd);
  endtask

  vec_t idle = '{0,0,0,0,0,0,0,0,0,
                 0,0,0,0,0,0,0,0,0};

  initial begin
    vec_t v;
    // st fl rw m2r mr mw alu rt wr | rw m2r wr alu wb flt cnt ck rd
    tbl[0]  = '{0,0,0,0,0,1,32'h10,32'hDEADBEEF,0,
                0,0,0,32'h10,32'h10,0,0,0,0};
    tbl[1]  = '{0,0,1,1,1,0,32'h10,0,8,
                1,1,8,32'h10,32'hDEADBEEF,0,0,1,32'hDEADBEEF};
    tbl[2]  = '{0,0,1,0,0,0,32'h9,0,3,
                1,0,3,32'h9,32'h9,0,0,0,0};
    tbl[3]  = '{0,0,0,0,0,1,32'h0,32'h11111111,0,
                0,0,0,0,0,0,0,0,0};
    tbl[4]  = '{0,0,1,1,1,0,32'h2,0,4,
                0,1,4,32'h2,0,1,1,1,0};
    tbl[5]  = '{0,0,1,0,0,0,32'h5,0,6,
                1,0,6,32'h5,32'h5,0,1,0,0};
    tbl[6]  = '{0,0,0,0,0,1,32'h400,32'h22222222,0,
                0,0,0,32'h400,32'h400,1,2,1,0};
    tbl[7]  = '{0,0,1,1,1,0,32'h0,0,9,
                1,1,9,0,32'h11111111,0,2,1,32'h11111111};
    tbl[8]  = '{1,0,0,0,0,1,32'h0,32'h33333333,0,
                1,1,9,0,32'h11111111,0,2,1,32'h11111111};
    tbl[9]  = '{0,1,1,0,0,1,32'h0,32'h33333333,7,
                0,0,0,0,0,0,2,0,0};
    tbl[10] = '{1,1,1,0,0,1,32'h0,32'h44444444,7,
                0,0,0,0,0,0,2,0,0};
    tbl[11] = '{0,0,1,1,1,0,32'h0,0,10,
                1,1,10,0,32'h11111111,0,2,1,32'h11111111};
    tbl[12] = '{1,0,1,1,1,0,32'h3,0,12,
                1,1,10,0,32'h11111111,0,2,1,32'h11111111};
    tbl[13] = '{0,0,1,1,1,0,32'h1,0,1,
                0,1,1,32'h1,0,1,3,1,0};
    tbl[14] = '{1,0,1,1,1,0,32'h1,0,1,
                0,1,1,32'h1,0,0,3,1,0};
    tbl[15] = '{0,1,1,1,1,0,32'h1,0,1,
                0,0,0,32'h1,32'h1,0,3,0,0};
    tbl[16] = '{0,0,0,0,0,1,32'h3FC,32'hCAFEF00D,0,
                0,0,0,32'h3FC,32'h3FC,0,3,0,0};
    tbl[17] = '{0,0,1,1,1,0,32'h3FC,0,31,
                1,1,31,32'h3FC,32'hCAFEF00D,0,3,1,32'hCAFEF00D};
    tbl[18] = '{0,0,0,1,1,1,32'h3FC,32'h12345678,0,
                0,1,0,32'h3FC,32'hCAFEF00D,0,3,1,32'hCAFEF00D};
    tbl[19] = '{0,0,1,1,1,0,32'h3FC,0,2,
                1,1,2,32'h3FC,32'h12345678,0,3,1,32'h12345678};
    tbl[20] = '{0,0,1,0,0,0,32'h7,0,0,
                1,0,0,32'h7,32'h7,0,3,0,0};

    reset_in = 1'b1;
    drive(idle);
    #1;
    chk("reset_init", outs(), '0);
    chk_rd("reset_init", '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_in = 1'b0;

    for (int i = 0; i < 21; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle, with a store held in reset.
    #3;
    reset_in = 1'b1;
    #1;
    chk("reset_async", outs(), '0);
    chk_rd("reset_async", '0);
    v = idle;
    v.mw = 1'b1;
    v.alu = 32'h3FC;
    v.rt = 32'h55555555;
    drive(v);
    @(posedge clk);
    #1;
    chk("reset_store", outs(), '0);
    reset_in = 1'b0;
    v = '{0,0,1,1,1,0,32'h3FC,0,2,
          1,1,2,32'h3FC,32'h12345678,0,0,1,32'h12345678};
    apply(v, "post_reset_load");

    // Saturating fault counter with one-cycle pulses.
    for (int i = 0; i < 260; i++) begin
      v = '{0,0,1,1,1,0,32'h2,0,5,
            0,1,5,32'h2,0,1,8'hFF,0,0};
      if (i < 255)
        v.e_cnt = 8'(i + 1);
      apply(v, $sformatf("sat%0d", i));
    end
    v = '{0,0,1,0,0,0,32'h4,0,5,
          1,0,5,32'h4,32'h4,0,8'hFF,0,0};
    apply(v, "sat_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
